// File: rtl/rsa_mc_pkg.sv
// Shared constants for the multi-channel RSA command wrapper: opcodes,
// FSM state encoding, status word layout and command/lane field positions.
package rsa_mc_pkg;

    localparam int CMD_W    = 32;
    localparam int OPC_W    = 4;
    localparam int MASK_LSB = 16;
    localparam int STAT_W   = 32;

    // Operand register selectors inside one lane
    localparam int N_OPND    = 5;
    localparam int OPND_MOD  = 0;
    localparam int OPND_RMOD = 1;
    localparam int OPND_RSQ  = 2;
    localparam int OPND_X    = 3;
    localparam int OPND_EXP  = 4;

    localparam logic [OPC_W-1:0] OP_LD_MOD   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LD_RMOD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LD_RSQ   = 4'd2;
    localparam logic [OPC_W-1:0] OP_LD_X     = 4'd3;
    localparam logic [OPC_W-1:0] OP_LD_EXP   = 4'd4;
    localparam logic [OPC_W-1:0] OP_RUN_EXP  = 4'd5;
    localparam logic [OPC_W-1:0] OP_RUN_MONT = 4'd6;
    localparam logic [OPC_W-1:0] OP_READ     = 4'd7;
    localparam logic [OPC_W-1:0] OP_CLEAR    = 4'd8;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_TIMEOUT  = 1;
    localparam int STAT_BAD_CMD  = 2;
    localparam int STAT_SEEN_LSB = 16;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_CLR     = 4'd2,
        ST_COMPUTE = 4'd3,
        ST_WRITE   = 4'd4,
        ST_DONE    = 4'd5
    } state_t;

endpackage

// File: rtl/rsa_mc_lane.sv
// One engine channel: the five operand registers, the captured result and
// the done-seen flag for that engine.
module rsa_mc_lane
    import rsa_mc_pkg::*;
#(
    parameter int OP_W = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_OPND-1:0] ld_en,
    input  logic [OP_W-1:0]   ld_data,
    input  logic              clr_seen,
    input  logic              cap,
    input  logic [OP_W-1:0]   res_in,
    output logic [OP_W-1:0]   modulus,
    output logic [OP_W-1:0]   rmodm,
    output logic [OP_W-1:0]   rsqmodm,
    output logic [OP_W-1:0]   x,
    output logic [OP_W-1:0]   exponent,
    output logic [OP_W-1:0]   result,
    output logic              done_seen
);

    // Operand loads, result capture and done-seen tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            modulus   <= '0;
            rmodm     <= '0;
            rsqmodm   <= '0;
            x         <= '0;
            exponent  <= '0;
            result    <= '0;
            done_seen <= 1'b0;
        end else begin
            if (ld_en[OPND_MOD])  modulus  <= ld_data;
            if (ld_en[OPND_RMOD]) rmodm    <= ld_data;
            if (ld_en[OPND_RSQ])  rsqmodm  <= ld_data;
            if (ld_en[OPND_X])    x        <= ld_data;
            if (ld_en[OPND_EXP])  exponent <= ld_data;
            if (clr_seen) begin
                done_seen <= 1'b0;
            end else if (cap) begin
                done_seen <= 1'b1;
                result    <= res_in;
            end
        end
    end

endmodule

// File: rtl/rsa_wrapper_mc.sv
// Multi-channel RSA command wrapper: decodes Arm commands, loads operand
// lanes into NUM_CH engines, runs a masked subset and returns the results.
//
// state   | meaning
// IDLE    | waiting for a command strobe
// LOAD    | accepting one inbound data beat into an operand register
// CLR     | one-cycle engine clear on masked channels
// COMPUTE | engines started, collecting results, timeout running
// WRITE   | presenting the result lanes to the host
// DONE    | done flag raised, waiting for acknowledge
module rsa_wrapper_mc
    import rsa_mc_pkg::*;
#(
    parameter int TX_SIZE = 1024,
    parameter int OP_W    = 512,
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 2**20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CMD_W-1:0]       arm_to_fpga_cmd,
    input  logic                   arm_to_fpga_cmd_valid,
    output logic                   fpga_to_arm_done,
    input  logic                   fpga_to_arm_done_read,
    input  logic                   arm_to_fpga_data_valid,
    output logic                   arm_to_fpga_data_ready,
    input  logic [TX_SIZE-1:0]     arm_to_fpga_data,
    output logic                   fpga_to_arm_data_valid,
    input  logic                   fpga_to_arm_data_ready,
    output logic [TX_SIZE-1:0]     fpga_to_arm_data,
    output logic [STAT_W-1:0]      fpga_to_arm_status,
    output logic [NUM_CH-1:0]      eng_clear,
    output logic [NUM_CH-1:0]      eng_start,
    output logic                   eng_mul_en,
    output logic [NUM_CH*OP_W-1:0] eng_modulus,
    output logic [NUM_CH*OP_W-1:0] eng_rmodm,
    output logic [NUM_CH*OP_W-1:0] eng_rsqmodm,
    output logic [NUM_CH*OP_W-1:0] eng_x,
    output logic [NUM_CH*OP_W-1:0] eng_exp,
    input  logic [NUM_CH-1:0]      eng_done,
    input  logic [NUM_CH*OP_W-1:0] eng_result
);

    if (TX_SIZE != NUM_CH*OP_W || NUM_CH < 1 || NUM_CH > 16) begin : g_param_err
        $error("rsa_wrapper_mc: TX_SIZE must equal NUM_CH*OP_W and NUM_CH must be 1..16");
    end

    localparam logic [NUM_CH-1:0] ALL_CH  = '1;
    localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [OPC_W-1:0]  op_q;
    logic [NUM_CH-1:0] mask_q;
    logic [31:0]       cnt;
    logic              timeout_q, bad_cmd_q, done_q;

    logic [OPC_W-1:0]  cmd_op;
    logic [NUM_CH-1:0] cmd_mask, mask_in;
    logic [NUM_CH-1:0] done_seen, cap, clr_seen;
    logic [N_OPND-1:0] ld_sel;
    logic              load_fire, all_done, to_hit, busy;
    logic              cmd_unused;

    assign cmd_op     = arm_to_fpga_cmd[OPC_W-1:0];
    assign cmd_mask   = arm_to_fpga_cmd[MASK_LSB +: NUM_CH];
    assign mask_in    = (cmd_mask == '0) ? ALL_CH : cmd_mask;
    assign cmd_unused = ^arm_to_fpga_cmd;

    assign load_fire = (state == ST_LOAD) && arm_to_fpga_data_valid;
    // An engine finishing in this very cycle counts, so a done on the
    // timeout cycle completes the run instead of flagging a timeout.
    assign all_done  = &(done_seen | cap | ~mask_q);
    assign to_hit    = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign fpga_to_arm_done = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    case (cmd_op)
                        OP_LD_MOD, OP_LD_RMOD, OP_LD_RSQ,
                        OP_LD_X, OP_LD_EXP:                state_nx = ST_LOAD;
                        OP_RUN_EXP, OP_RUN_MONT, OP_CLEAR: state_nx = ST_CLR;
                        OP_READ:                           state_nx = ST_WRITE;
                        default:                           state_nx = ST_DONE;
                    endcase
                end
            end
            ST_LOAD:    if (arm_to_fpga_data_valid) state_nx = ST_DONE;
            ST_CLR:     state_nx = (op_q == OP_CLEAR) ? ST_DONE : ST_COMPUTE;
            ST_COMPUTE: if (all_done || to_hit) state_nx = ST_DONE;
            ST_WRITE:   if (fpga_to_arm_data_ready) state_nx = ST_DONE;
            ST_DONE:    if (done_q && fpga_to_arm_done_read) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Handshake, engine control and status outputs
    always_comb begin
        busy                   = (state != ST_IDLE) && (state != ST_DONE);
        arm_to_fpga_data_ready = (state == ST_LOAD);
        fpga_to_arm_data_valid = (state == ST_WRITE);
        eng_clear              = (state == ST_CLR)     ? mask_q : '0;
        eng_start              = (state == ST_COMPUTE) ? mask_q : '0;
        eng_mul_en             = (state == ST_COMPUTE) && (op_q == OP_RUN_MONT);
        fpga_to_arm_status                               = '0;
        fpga_to_arm_status[STAT_BUSY]                    = busy;
        fpga_to_arm_status[STAT_TIMEOUT]                 = timeout_q;
        fpga_to_arm_status[STAT_BAD_CMD]                 = bad_cmd_q;
        fpga_to_arm_status[STAT_SEEN_LSB +: NUM_CH]      = done_seen;
    end

    // Lane strobes: operand select, done-seen clear and result capture
    always_comb begin
        ld_sel = '0;
        case (op_q)
            OP_LD_MOD:  ld_sel[OPND_MOD]  = 1'b1;
            OP_LD_RMOD: ld_sel[OPND_RMOD] = 1'b1;
            OP_LD_RSQ:  ld_sel[OPND_RSQ]  = 1'b1;
            OP_LD_X:    ld_sel[OPND_X]    = 1'b1;
            OP_LD_EXP:  ld_sel[OPND_EXP]  = 1'b1;
            default:    ld_sel = '0;
        endcase
        clr_seen = (state == ST_CLR)     ? mask_q : '0;
        cap      = (state == ST_COMPUTE) ? (mask_q & eng_done & ~done_seen) : '0;
    end

    // Command latch, compute timer, sticky flags and registered done
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            mask_q    <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
            bad_cmd_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && arm_to_fpga_cmd_valid) begin
                op_q      <= cmd_op;
                mask_q    <= mask_in;
                timeout_q <= 1'b0;
                bad_cmd_q <= (cmd_op > OP_CLEAR);
            end
            if (state == ST_CLR) begin
                cnt <= '0;
            end else if (state == ST_COMPUTE) begin
                cnt <= cnt + 32'd1;
                if (to_hit && !all_done) timeout_q <= 1'b1;
            end
            done_q <= (state == ST_DONE) && !(done_q && fpga_to_arm_done_read);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        rsa_mc_lane #(.OP_W(OP_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .ld_en     ((load_fire && mask_q[i]) ? ld_sel : '0),
            .ld_data   (arm_to_fpga_data[i*OP_W +: OP_W]),
            .clr_seen  (clr_seen[i]),
            .cap       (cap[i]),
            .res_in    (eng_result[i*OP_W +: OP_W]),
            .modulus   (eng_modulus[i*OP_W +: OP_W]),
            .rmodm     (eng_rmodm[i*OP_W +: OP_W]),
            .rsqmodm   (eng_rsqmodm[i*OP_W +: OP_W]),
            .x         (eng_x[i*OP_W +: OP_W]),
            .exponent  (eng_exp[i*OP_W +: OP_W]),
            .result    (fpga_to_arm_data[i*OP_W +: OP_W]),
            .done_seen (done_seen[i])
        );
    end

endmodule

// File: tb/tb_rsa_wrapper_mc.sv
// Directed bench for rsa_wrapper_mc with two 32-bit lanes and stub engines
// that raise done after a programmable number of start cycles.
module tb_rsa_wrapper_mc;

    localparam int OP_W    = 32;
    localparam int NUM_CH  = 2;
    localparam int TX_SIZE = NUM_CH*OP_W;
    localparam int TIMEOUT = 100;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [31:0]            cmd = '0;
    logic                   cmd_valid = 1'b0;
    logic                   done;
    logic                   done_read = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [TX_SIZE-1:0]     in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [TX_SIZE-1:0]     out_data;
    logic [31:0]            status;
    logic [NUM_CH-1:0]      eng_clear, eng_start, eng_done;
    logic                   eng_mul_en;
    logic [TX_SIZE-1:0]     eng_modulus, eng_rmodm, eng_rsqmodm, eng_x, eng_exp, eng_result;

    int unsigned            lat [NUM_CH];
    logic [OP_W-1:0]        res_val [NUM_CH];
    int                     n_cmp = 0;
    int                     n_err = 0;

    always #5 clk = ~clk;

    rsa_wrapper_mc #(.TX_SIZE(TX_SIZE), .OP_W(OP_W), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (cmd),
        .arm_to_fpga_cmd_valid  (cmd_valid),
        .fpga_to_arm_done       (done),
        .fpga_to_arm_done_read  (done_read),
        .arm_to_fpga_data_valid (in_valid),
        .arm_to_fpga_data_ready (in_ready),
        .arm_to_fpga_data       (in_data),
        .fpga_to_arm_data_valid (out_valid),
        .fpga_to_arm_data_ready (out_ready),
        .fpga_to_arm_data       (out_data),
        .fpga_to_arm_status     (status),
        .eng_clear              (eng_clear),
        .eng_start              (eng_start),
        .eng_mul_en             (eng_mul_en),
        .eng_modulus            (eng_modulus),
        .eng_rmodm              (eng_rmodm),
        .eng_rsqmodm            (eng_rsqmodm),
        .eng_x                  (eng_x),
        .eng_exp                (eng_exp),
        .eng_done               (eng_done),
        .eng_result             (eng_result)
    );

    // Stub engines: done level once start has been high for lat[g] cycles
    for (genvar g = 0; g < NUM_CH; g++) begin : g_eng
        int unsigned scnt;
        always_ff @(posedge clk) begin
            if (reset || eng_clear[g]) scnt <= 0;
            else if (eng_start[g])     scnt <= scnt + 1;
        end
        assign eng_done[g] = eng_start[g] && (scnt >= lat[g]);
        assign eng_result[g*OP_W +: OP_W] = res_val[g];
    end

    logic mon_clr = 1'b1;
    int   start_cyc, clr_cyc, mul_cyc, mul_start_cyc, clr_then_start;
    logic prev_start, prev_clear;

    // Cycle counters for start, clear and multiply-mode activity
    always_ff @(posedge clk) begin
        if (mon_clr) begin
            start_cyc      <= 0;
            clr_cyc        <= 0;
            mul_cyc        <= 0;
            mul_start_cyc  <= 0;
            clr_then_start <= 0;
        end else begin
            if (eng_start != '0)               start_cyc     <= start_cyc + 1;
            if (eng_clear != '0)               clr_cyc       <= clr_cyc + 1;
            if (eng_mul_en)                    mul_cyc       <= mul_cyc + 1;
            if (eng_mul_en && eng_start != '0) mul_start_cyc <= mul_start_cyc + 1;
            if (eng_start != '0 && !prev_start && prev_clear) clr_then_start <= clr_then_start + 1;
        end
        prev_start <= (eng_start != '0);
        prev_clear <= (eng_clear != '0);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [3:0] opc, input logic [NUM_CH-1:0] mask);
        cmd       = 32'(opc) | (32'(mask) << 16);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic ack(input string tag);
        done_read = 1'b1;
        @(negedge clk);
        done_read = 1'b0;
        chk({tag, "_done_drop"}, done, 0);
    endtask

    task automatic do_load(input string tag, input logic [3:0] opc,
                           input logic [NUM_CH-1:0] mask, input logic [TX_SIZE-1:0] d);
        send_cmd(opc, mask);
        chk({tag, "_ready"}, in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_ready_drop"}, in_ready, 0);
        chk({tag, "_done_early"}, done, 0);
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        ack(tag);
    endtask

    task automatic do_run(input string tag, input logic [3:0] opc, input logic [NUM_CH-1:0] clr_exp);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        send_cmd(opc, '0);
        chk({tag, "_clear"}, eng_clear, clr_exp);
        chk({tag, "_busy"}, status[0], 1);
        wait_done(tag);
        chk({tag, "_idle_busy"}, status[0], 0);
    endtask

    task automatic do_read(input string tag, input logic [TX_SIZE-1:0] exp);
        send_cmd(4'd7, '0);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        chk({tag, "_valid_hold"}, out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        wait_done(tag);
        ack(tag);
        chk({tag, "_data_kept"}, out_data, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            lat[i]     = 0;
            res_val[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_ctrl", {eng_start, eng_clear, eng_mul_en, in_ready, out_valid}, 0);
        chk("rst_operands", eng_modulus | eng_rmodm | eng_rsqmodm | eng_x | eng_exp, 0);
        chk("rst_result", out_data, 0);
        reset   = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);

        do_load("ld_mod", 4'd0, 2'b00, 64'h22222222_11111111);
        chk("ld_mod_val", eng_modulus, 64'h22222222_11111111);

        do_load("ld_x_all", 4'd3, 2'b00, 64'h44444444_33333333);
        do_load("ld_x_m2", 4'd3, 2'b10, 64'h66666666_55555555);
        chk("ld_x_mask", eng_x, 64'h66666666_33333333);
        chk("ld_x_mod_kept", eng_modulus, 64'h22222222_11111111);

        do_load("ld_exp_m1", 4'd4, 2'b01, 64'h77777777_88888888);
        chk("ld_exp_mask", eng_exp, 64'h00000000_88888888);

        lat[0] = 50; lat[1] = 80;
        res_val[0] = 32'hAAAA0001; res_val[1] = 32'hBBBB0002;
        do_run("exp", 4'd5, 2'b11);
        chk("exp_start_cycles", 64'(start_cyc), 81);
        chk("exp_clear_cycles", 64'(clr_cyc), 1);
        chk("exp_clear_then_start", 64'(clr_then_start), 1);
        chk("exp_mul_en", 64'(mul_cyc), 0);
        chk("exp_timeout", status[1], 0);
        chk("exp_seen", status[17:16], 2'b11);
        ack("exp");
        do_read("rd_exp", 64'hBBBB0002_AAAA0001);

        lat[0] = 5; lat[1] = 7;
        res_val[0] = 32'hCCCC0003; res_val[1] = 32'hDDDD0004;
        do_run("mont", 4'd6, 2'b11);
        chk("mont_start_cycles", 64'(start_cyc), 8);
        chk("mont_mul_cycles", 64'(mul_cyc), 8);
        chk("mont_mul_with_start", 64'(mul_start_cyc), 8);
        chk("mont_clear_then_start", 64'(clr_then_start), 1);
        ack("mont");
        do_read("rd_mont", 64'hDDDD0004_CCCC0003);

        lat[0] = 20; lat[1] = 100000;
        res_val[0] = 32'hA2A2A2A2; res_val[1] = 32'hEEEEEEEE;
        do_run("tmo", 4'd5, 2'b11);
        chk("tmo_start_cycles", 64'(start_cyc), 100);
        chk("tmo_flag", status[1], 1);
        chk("tmo_seen", status[17:16], 2'b01);
        ack("tmo");
        do_read("rd_tmo", 64'hDDDD0004_A2A2A2A2);

        lat[0] = 10; lat[1] = 99;
        res_val[0] = 32'h10101010; res_val[1] = 32'h99999999;
        do_run("edge", 4'd5, 2'b11);
        chk("edge_start_cycles", 64'(start_cyc), 100);
        chk("edge_no_timeout", status[1], 0);
        chk("edge_seen", status[17:16], 2'b11);
        ack("edge");
        do_read("rd_edge", 64'h99999999_10101010);

        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        send_cmd(4'd8, 2'b10);
        chk("clr_mask", eng_clear, 2'b10);
        @(negedge clk);
        chk("clr_pulse_end", eng_clear, 2'b00);
        wait_done("clr");
        chk("clr_seen", status[17:16], 2'b01);
        chk("clr_cycles", 64'(clr_cyc), 1);
        chk("clr_no_start", 64'(start_cyc), 0);
        ack("clr");

        send_cmd(4'hF, '0);
        chk("bad_no_ready", in_ready, 0);
        chk("bad_no_valid", out_valid, 0);
        wait_done("bad");
        chk("bad_flag", status[2], 1);
        ack("bad");
        do_load("ld_rmod", 4'd1, 2'b00, 64'h1234ABCD_5678EF01);
        chk("ld_rmod_val", eng_rmodm, 64'h1234ABCD_5678EF01);
        chk("bad_flag_cleared", status[2], 0);
        do_load("ld_rsq", 4'd2, 2'b00, 64'h0F0F0F0F_F0F0F0F0);
        chk("ld_rsq_val", eng_rsqmodm, 64'h0F0F0F0F_F0F0F0F0);

        lat[0] = 1000; lat[1] = 1000;
        send_cmd(4'd5, '0);
        @(negedge clk);
        chk("rstmid_start", eng_start, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_start_drop", eng_start, 0);
        chk("rstmid_clear", eng_clear, 0);
        chk("rstmid_status", status, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_operands", eng_modulus | eng_rmodm | eng_rsqmodm | eng_x | eng_exp, 0);
        chk("rstmid_result", out_data, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_wrapper_mc.md
Name: rsa_wrapper_mc

Overview:
Parametrised successor of the single-pair RSA command wrapper. Decodes 32-bit Arm commands and loads operand slices from the TX_SIZE-bit Arm bus into NUM_CH independent exponentiation/Montgomery engines. Starts a masked subset of the engines, collects their results and returns them over the same handshake. Engines sit outside this block; adds channel masking, an uniform lane mapping, a compute timeout and a status word.

Parameters:
TX_SIZE, 1024, Arm<->FPGA data bus width
OP_W, 512, operand width per channel; TX_SIZE = NUM_CH*OP_W (elaboration error otherwise)
NUM_CH, 2, number of engines (1..16)
TIMEOUT, 2**20, compute cycles before abort; 0 disables the timeout

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
arm_to_fpga_cmd  in  32  [3:0] opcode, [16+:NUM_CH] channel mask
arm_to_fpga_cmd_valid  in  1  command strobe, sampled in IDLE only
fpga_to_arm_done  out  1  command complete, held until acknowledged
fpga_to_arm_done_read  in  1  done acknowledge
arm_to_fpga_data_valid  in  1  inbound data valid
arm_to_fpga_data_ready  out  1  inbound data ready
arm_to_fpga_data  in  TX_SIZE  inbound data, lane i = bits[i*OP_W +: OP_W]
fpga_to_arm_data_valid  out  1  outbound data valid
fpga_to_arm_data_ready  in  1  outbound data ready
fpga_to_arm_data  out  TX_SIZE  result lanes, same mapping as inbound
fpga_to_arm_status  out  32  [0] busy, [1] timeout, [2] bad_cmd, [16+:NUM_CH] done-seen per channel
eng_clear  out  NUM_CH  one-cycle engine clear pulse per channel
eng_start  out  NUM_CH  level start, held for the whole COMPUTE state
eng_mul_en  out  1  1 = Montgomery-multiply mode, 0 = exponentiation
eng_modulus, eng_rmodm, eng_rsqmodm, eng_x, eng_exp  out  NUM_CH*OP_W each  operand registers, lane i for engine i
eng_done  in  NUM_CH  per-engine done level
eng_result  in  NUM_CH*OP_W  per-engine result

Behaviour:
- Reset values: all outputs 0; all operand and result registers 0; state IDLE.
- Opcodes:
  - 0 LD_MOD, 1 LD_RMOD, 2 LD_RSQ, 3 LD_X, 4 LD_EXP
  - 5 RUN_EXP, 6 RUN_MONT, 7 READ, 8 CLEAR
  - Any other opcode sets bad_cmd and goes to DONE.
- State IDLE: when cmd_valid is high, latch the opcode and mask (mask==0 means all channels), clear the timeout and bad_cmd flags, and branch on the opcode.
- State LOAD (LD_*):
  - data_ready is driven 1 from the first cycle in LOAD.
  - On valid&&ready, write lane i into the selected operand register for every masked i; unmasked lanes keep their value.
  - data_ready drops the next cycle; go to DONE.
- State CLR (entered on RUN_* and CLEAR):
  - Pulse eng_clear[i] for exactly 1 cycle on masked channels.
  - Clear the done_seen bits for those channels.
  - CLEAR then goes to DONE; RUN_* goes to COMPUTE.
- State COMPUTE:
  - eng_start[i] = 1 for masked i; eng_mul_en = 1 for RUN_MONT.
  - busy = 1; the timeout counter increments every cycle.
  - First cycle eng_done[i] is seen high: capture eng_result lane i and set done_seen[i].
  - When all masked done_seen are set: drop eng_start, go to DONE.
  - When the counter reaches TIMEOUT-1: set timeout, drop eng_start, keep partial results, go to DONE.
- State WRITE (READ):
  - data_valid is driven 1 from the first cycle in WRITE; data is the result register, all lanes.
  - On valid&&ready, drop data_valid and go to DONE. The result register is unchanged.
- State DONE:
  - fpga_to_arm_done = 1 is registered, asserted the cycle after entry.
  - When done_read is high, done drops and the state returns to IDLE.
- cmd_valid outside IDLE is ignored; the host must wait for done.
- Simultaneous events:
  - eng_done and timeout on the same cycle: the result is captured and timeout is NOT set.
  - valid arriving on the same cycle as state entry, before ready is high: no transfer.
- Reset mid-operation: returns to IDLE in 1 cycle; eng_start and eng_clear drop; operand registers are zeroed.
- Status bit busy = (state != IDLE && state != DONE).

Decomposition:
- Package rsa_mc_pkg holds:
  - opcode constants
  - state encoding (4-bit)
  - status bit indices
  - the lane-slice helper width constants
- One natural sub-module, rsa_mc_lane: per-channel operand/result registers and the done_seen flag, instantiated NUM_CH times under generate.

Test Plan:
- LD_MOD with mask 0, data lane0=0x11.., lane1=0x22.. -> eng_modulus lane0=0x11.., lane1=0x22..; done high 1 cycle after transfer, low after done_read.
- LD_X mask=0b10 after LD_X mask 0 -> only lane1 changes; lane0 retains its previous value.
- RUN_EXP mask 0, stub engines assert done after 50 and 80 cycles with results A and B -> eng_start high for 81 cycles, then READ returns {B,A} and status[17:16]=2'b11.
- RUN_MONT -> eng_mul_en=1 throughout COMPUTE; eng_clear pulses exactly 1 cycle before eng_start rises.
- TIMEOUT=100, engine 1 never completes -> timeout=1 at cycle 100, lane1 result unchanged, done asserted.
- Opcode 0xF -> bad_cmd=1, no data handshake. Separately: reset asserted in COMPUTE -> all outputs 0 on the next cycle.
